// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by an internal word-addressed memory.
// Independent read and write state machines share one memory array.
module axi_mem_responder #(
  parameter int unsigned ID_WIDTH     = 13,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int unsigned OFF_W   = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
  localparam int unsigned WORD_AW = ADDR_WIDTH - OFF_W;
  localparam int unsigned LAT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = (READ_LATENCY == 0) ? '0 : LAT_W'(READ_LATENCY - 1);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Byte offset within a full-width beat carries no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_araddr[OFF_W-1:0], s_axi_awaddr[OFF_W-1:0]};

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic [WORD_AW-1:0] next_word(input logic [WORD_AW-1:0] w,
                                                   input logic [7:0] len,
                                                   input logic [1:0] burst);
    logic [WORD_AW-1:0] mask;
    mask = WORD_AW'(len);
    if (burst == BURST_FIXED) return w;
    if (burst == BURST_WRAP && wrap_len_ok(len))
      return (w & ~mask) | ((w + WORD_AW'(1)) & mask);
    return w + WORD_AW'(1);
  endfunction

  function automatic logic out_of_range(input logic [WORD_AW-1:0] w);
    return |w[WORD_AW-1:IDX_W];
  endfunction

  function automatic logic [1:0] beat_resp(input logic [WORD_AW-1:0] w,
                                           input logic [7:0] len,
                                           input logic [1:0] burst);
    if (out_of_range(w)) return RESP_DECERR;
    if (burst == BURST_RSVD || (burst == BURST_WRAP && !wrap_len_ok(len))) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // ---------------- read path ----------------
  r_state_t              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [WORD_AW-1:0]    r_word_q, r_word_d;
  logic [7:0]            r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic [LAT_W-1:0]      r_lat_q, r_lat_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  r_fetch;
  logic [WORD_AW-1:0]    r_fetch_word;
  logic [7:0]            r_fetch_beat;

  always_comb begin
    r_state_d    = r_state_q;
    r_id_d       = r_id_q;
    r_word_d     = r_word_q;
    r_len_d      = r_len_q;
    r_burst_d    = r_burst_q;
    r_beat_d     = r_beat_q;
    r_lat_d      = r_lat_q;
    arready_d    = arready_q;
    rvalid_d     = rvalid_q;
    rlast_d      = rlast_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    r_fetch      = 1'b0;
    r_fetch_word = r_word_q;
    r_fetch_beat = r_beat_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          arready_d = 1'b0;
          r_id_d    = s_axi_arid;
          r_word_d  = s_axi_araddr[ADDR_WIDTH-1:OFF_W];
          r_len_d   = s_axi_arlen;
          r_burst_d = s_axi_arburst;
          r_beat_d  = 8'd0;
          r_lat_d   = '0;
          if (READ_LATENCY == 0) begin
            r_state_d    = R_DATA;
            r_fetch      = 1'b1;
            r_fetch_word = s_axi_araddr[ADDR_WIDTH-1:OFF_W];
            r_fetch_beat = 8'd0;
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_lat_q == LAT_LAST) begin
          r_state_d    = R_DATA;
          r_fetch      = 1'b1;
          r_fetch_word = r_word_q;
          r_fetch_beat = 8'd0;
        end else begin
          r_lat_d = r_lat_q + LAT_W'(1);
        end
      end
      R_DATA: begin
        if (rvalid_q && s_axi_rready) begin
          if (r_beat_q == r_len_q) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            r_word_d     = next_word(r_word_q, r_len_q, r_burst_q);
            r_beat_d     = r_beat_q + 8'd1;
            r_fetch      = 1'b1;
            r_fetch_word = r_word_d;
            r_fetch_beat = r_beat_d;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Load the beat presented next; memory is read before any same-edge write lands.
    if (r_fetch) begin
      rvalid_d = 1'b1;
      rresp_d  = beat_resp(r_fetch_word, r_len_d, r_burst_d);
      rlast_d  = (r_fetch_beat == r_len_d);
      rdata_d  = out_of_range(r_fetch_word) ? '0 : mem[r_fetch_word[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_word_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_beat_q  <= '0;
      r_lat_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_word_q  <= r_word_d;
      r_len_q   <= r_len_d;
      r_burst_q <= r_burst_d;
      r_beat_q  <= r_beat_d;
      r_lat_q   <= r_lat_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rid     = r_id_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;

  // ---------------- write path ----------------
  w_state_t            w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] w_id_q, w_id_d;
  logic [WORD_AW-1:0]  w_word_q, w_word_d;
  logic [7:0]          w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [1:0]          w_burst_q, w_burst_d;
  logic [1:0]          w_err_q, w_err_d;
  logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [1:0]          w_resp_c, w_acc_c;
  logic                mem_we_c;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_word_d  = w_word_q;
    w_len_d   = w_len_q;
    w_burst_d = w_burst_q;
    w_beat_d  = w_beat_q;
    w_err_d   = w_err_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mem_we_c  = 1'b0;
    w_resp_c  = beat_resp(w_word_q, w_len_q, w_burst_q);
    w_acc_c   = worst(w_err_q, w_resp_c);
    if (s_axi_wlast != (w_beat_q == w_len_q)) w_acc_c = worst(w_acc_c, RESP_SLVERR);
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && awready_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_id_d    = s_axi_awid;
          w_word_d  = s_axi_awaddr[ADDR_WIDTH-1:OFF_W];
          w_len_d   = s_axi_awlen;
          w_burst_d = s_axi_awburst;
          w_beat_d  = 8'd0;
          w_err_d   = RESP_OKAY;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          mem_we_c = (w_resp_c != RESP_DECERR);
          w_err_d  = w_acc_c;
          if (w_beat_q == w_len_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_acc_c;
            w_state_d = W_RESP;
          end else begin
            w_word_d = next_word(w_word_q, w_len_q, w_burst_q);
            w_beat_d = w_beat_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && s_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_word_q  <= '0;
      w_len_q   <= '0;
      w_burst_q <= '0;
      w_beat_q  <= '0;
      w_err_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_word_q  <= w_word_d;
      w_len_q   <= w_len_d;
      w_burst_q <= w_burst_d;
      w_beat_q  <= w_beat_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
        if (s_axi_wstrb[b]) mem[w_word_q[IDX_W-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = w_id_q;
  assign s_axi_bresp   = bresp_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder.
module tb_axi_mem_responder;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [12:0] s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
  logic [63:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
  logic [7:0]  s_axi_awlen, s_axi_arlen, s_axi_wstrb;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  axi_mem_responder #(
    .ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64), .STRB_WIDTH(8),
    .MEM_WORDS(1024), .READ_LATENCY(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] wr_data [16];
  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [12:0] rd_id   [16];
  int          rd_lat;
  logic [1:0]  b_resp;
  logic [12:0] b_id;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_handshake(input logic [12:0] id, input logic [63:0] addr,
                              input logic [7:0] len, input logic [1:0] burst);
    int n;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (s_axi_arready !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL ar_timeout: arready never rose (got %b, expected 1)", s_axi_arready);
    end
    step();
    s_axi_arvalid = 1'b0;
  endtask

  // Runs a read burst with rready held high; records every beat.
  task automatic do_read(input logic [12:0] id, input logic [63:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int beat;
    int lat;
    s_axi_rready = 1'b1;
    ar_handshake(id, addr, len, burst);
    lat = 1; beat = 0; rd_lat = -1;
    while (beat <= int'(len) && lat < 300) begin
      if (s_axi_rvalid === 1'b1) begin
        if (beat == 0) rd_lat = lat;
        rd_data[beat] = s_axi_rdata; rd_resp[beat] = s_axi_rresp;
        rd_last[beat] = s_axi_rlast; rd_id[beat] = s_axi_rid;
        beat++;
      end
      step(); lat++;
    end
    if (beat <= int'(len)) begin
      checks++; errors++;
      $display("FAIL r_timeout: got %0d beats, expected %0d", beat, int'(len) + 1);
    end
  endtask

  // Runs a write burst from wr_data[]; wlast is raised on beat last_idx.
  task automatic do_write(input logic [12:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [7:0] strb, input int last_idx);
    int n;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    n = 0;
    while (s_axi_awready !== 1'b1 && n < 50) begin step(); n++; end
    step();
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = wr_data[i]; s_axi_wstrb = strb;
      s_axi_wlast = (i == last_idx);
      n = 0;
      while (s_axi_wready !== 1'b1 && n < 50) begin step(); n++; end
      step();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    s_axi_bready = 1'b1;
    n = 0;
    while (s_axi_bvalid !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL b_timeout: bvalid got %b, expected 1", s_axi_bvalid);
    end
    b_resp = s_axi_bresp; b_id = s_axi_bid;
    step();
    s_axi_bready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid, s_axi_rlast} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 000000",
               {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid, s_axi_rlast});
    end
    reset_n = 1'b1;
    step();
    checks++;
    if ({s_axi_arready, s_axi_awready, s_axi_wready} !== 3'b110) begin
      errors++;
      $display("FAIL post_reset_ready: got %b, expected 110", {s_axi_arready, s_axi_awready, s_axi_wready});
    end
  endtask

  task automatic test_incr();
    logic [63:0] exp;
    for (int i = 0; i < 4; i++) wr_data[i] = 64'hA0 + 64'(i);
    do_write(13'h0AB, 64'h100, 8'd3, 2'b01, 8'hFF, 3);
    checks++;
    if (b_resp !== 2'b00 || b_id !== 13'h0AB) begin
      errors++; $display("FAIL incr_b: got resp %b id %h, expected 00 id 0ab", b_resp, b_id);
    end
    do_read(13'h155, 64'h100, 8'd3, 2'b01);
    checks++;
    if (rd_lat !== 3) begin errors++; $display("FAIL incr_latency: got %0d, expected 3", rd_lat); end
    for (int i = 0; i < 4; i++) begin
      exp = 64'hA0 + 64'(i);
      checks++;
      if (rd_data[i] !== exp || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3) || rd_id[i] !== 13'h155) begin
        errors++;
        $display("FAIL incr_beat%0d: got data %h resp %b last %b id %h, expected %h 00 %b 155",
                 i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], exp, (i == 3));
      end
    end
    checks++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      errors++; $display("FAIL incr_end: got rvalid %b arready %b, expected 0 1", s_axi_rvalid, s_axi_arready);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp [4];
    exp[0] = 64'd3; exp[1] = 64'd0; exp[2] = 64'd1; exp[3] = 64'd2;
    for (int i = 0; i < 4; i++) wr_data[i] = 64'(i);
    do_write(13'h001, 64'h100, 8'd3, 2'b01, 8'hFF, 3);
    do_read(13'h002, 64'h118, 8'd3, 2'b10);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== exp[i] || rd_resp[i] !== 2'b00) begin
        errors++; $display("FAIL wrap_beat%0d: got %h/%b, expected %h/00", i, rd_data[i], rd_resp[i], exp[i]);
      end
    end
  endtask

  task automatic test_decerr();
    wr_data[0] = 64'h1111; wr_data[1] = 64'h2222;
    do_write(13'h003, 64'h0, 8'd1, 2'b01, 8'hFF, 1);
    wr_data[0] = 64'hDEAD0; wr_data[1] = 64'hDEAD1;
    do_write(13'h004, 64'h2000, 8'd1, 2'b01, 8'hFF, 1);
    checks++;
    if (b_resp !== 2'b11) begin errors++; $display("FAIL decerr_b: got %b, expected 11", b_resp); end
    do_read(13'h005, 64'h2000, 8'd1, 2'b01);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_resp[i] !== 2'b11 || rd_data[i] !== 64'h0) begin
        errors++; $display("FAIL decerr_r%0d: got %b/%h, expected 11/0", i, rd_resp[i], rd_data[i]);
      end
    end
    do_read(13'h006, 64'h0, 8'd1, 2'b01);
    checks++;
    if (rd_data[0] !== 64'h1111 || rd_data[1] !== 64'h2222) begin
      errors++; $display("FAIL decerr_mem: got %h %h, expected 1111 2222", rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_stall_and_errors();
    logic        rr  [6];
    logic [63:0] exd [6];
    int n;
    rr[0] = 1; rr[1] = 0; rr[2] = 0; rr[3] = 1; rr[4] = 1; rr[5] = 1;
    exd[0] = 0; exd[1] = 1; exd[2] = 1; exd[3] = 1; exd[4] = 2; exd[5] = 3;
    s_axi_rready = 1'b1;
    ar_handshake(13'h007, 64'h100, 8'd3, 2'b01);
    n = 0;
    while (s_axi_rvalid !== 1'b1 && n < 20) begin step(); n++; end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== exd[i] || s_axi_rlast !== (i == 5)) begin
        errors++;
        $display("FAIL stall_s%0d: got v%b %h last %b, expected v1 %h last %b",
                 i, s_axi_rvalid, s_axi_rdata, s_axi_rlast, exd[i], (i == 5));
      end
      s_axi_rready = rr[i];
      step();
    end
    // W data offered before AW must wait.
    for (int i = 0; i < 4; i++) wr_data[i] = 64'hB0 + 64'(i);
    s_axi_wvalid = 1'b1; s_axi_wdata = wr_data[0]; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s_axi_wready !== 1'b0) begin errors++; $display("FAIL w_before_aw%0d: got %b, expected 0", i, s_axi_wready); end
    end
    s_axi_wvalid = 1'b0;
    do_write(13'h008, 64'h200, 8'd3, 2'b01, 8'hFF, 1);
    checks++;
    if (b_resp !== 2'b10 || b_id !== 13'h008) begin
      errors++; $display("FAIL wlast_b: got %b id %h, expected 10 id 008", b_resp, b_id);
    end
    do_read(13'h009, 64'h200, 8'd3, 2'b01);
    checks++;
    if (rd_data[0] !== 64'hB0 || rd_data[3] !== 64'hB3) begin
      errors++; $display("FAIL wlast_data: got %h %h, expected b0 b3", rd_data[0], rd_data[3]);
    end
  endtask

  task automatic test_partial_strobe();
    wr_data[0] = 64'h11223344_55667788;
    do_write(13'h00A, 64'h300, 8'd0, 2'b01, 8'hFF, 0);
    wr_data[0] = 64'hFFFFFFFF_FFFFFFFF;
    do_write(13'h00B, 64'h300, 8'd0, 2'b01, 8'h0F, 0);
    do_read(13'h00C, 64'h300, 8'd0, 2'b01);
    checks++;
    if (rd_data[0] !== 64'h11223344_FFFFFFFF || rd_last[0] !== 1'b1) begin
      errors++; $display("FAIL strobe: got %h last %b, expected 11223344ffffffff last 1", rd_data[0], rd_last[0]);
    end
  endtask

  task automatic test_burst_types();
    do_read(13'h00D, 64'h100, 8'd2, 2'b11);
    checks++;
    if (rd_data[0] !== 64'd0 || rd_data[2] !== 64'd2 || rd_resp[0] !== 2'b10 || rd_resp[2] !== 2'b10) begin
      errors++; $display("FAIL rsvd_burst: got %h %h %b %b, expected 0 2 10 10", rd_data[0], rd_data[2], rd_resp[0], rd_resp[2]);
    end
    do_read(13'h00E, 64'h100, 8'd2, 2'b10);
    checks++;
    if (rd_data[1] !== 64'd1 || rd_data[2] !== 64'd2 || rd_resp[1] !== 2'b10) begin
      errors++; $display("FAIL bad_wrap: got %h %h %b, expected 1 2 10", rd_data[1], rd_data[2], rd_resp[1]);
    end
    do_read(13'h00F, 64'h108, 8'd2, 2'b00);
    checks++;
    if (rd_data[0] !== 64'd1 || rd_data[2] !== 64'd1 || rd_resp[2] !== 2'b00) begin
      errors++; $display("FAIL fixed: got %h %h %b, expected 1 1 00", rd_data[0], rd_data[2], rd_resp[2]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    s_axi_rready = 1'b1;
    ar_handshake(13'h010, 64'h100, 8'd3, 2'b01);
    n = 0;
    while (s_axi_rvalid !== 1'b1 && n < 20) begin step(); n++; end
    step();
    checks++;
    if (s_axi_rdata !== 64'd1) begin errors++; $display("FAIL mid_beat1: got %h, expected 1", s_axi_rdata); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got rvalid %b arready %b, expected 0 0", s_axi_rvalid, s_axi_arready);
    end
    step(); step();
    reset_n = 1'b1;
    step();
    checks++;
    if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
      errors++; $display("FAIL mid_release: got arready %b rvalid %b, expected 1 0", s_axi_arready, s_axi_rvalid);
    end
    do_read(13'h011, 64'h100, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== 64'(i) || rd_last[i] !== (i == 3) || rd_id[i] !== 13'h011) begin
        errors++; $display("FAIL mid_reread%0d: got %h last %b id %h, expected %0d last %b id 011",
                           i, rd_data[i], rd_last[i], rd_id[i], i, (i == 3));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arburst = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    test_reset();
    test_incr();
    test_wrap();
    test_decerr();
    test_stall_and_errors();
    test_partial_strobe();
    test_burst_types();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
